// File: rtl/cb_exec_if.sv
// Bundle of the decoder, register-file, bus and alu8 signals around cb_exec_ctrl.
// master: the sequencer itself; slave: the surrounding datapath.
interface cb_exec_if;
  logic        req_valid;
  logic [7:0]  req_op;
  logic        req_ready;
  logic [15:0] hl_in;
  logic [7:0]  flags_in;

  logic [2:0]  rf_raddr;
  logic [7:0]  rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;

  logic        flags_we;
  logic [7:0]  flags_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_op;
  logic        alu_cin;
  logic [7:0]  alu_res;
  logic [7:0]  alu_flags;

  logic        done;

  modport master (
    input  req_valid, req_op, hl_in, flags_in, rf_rdata, mem_ack, mem_rdata,
           alu_res, alu_flags,
    output req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, flags_we, flags_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, alu_a, alu_b, alu_op, alu_cin, done
  );

  modport slave (
    output req_valid, req_op, hl_in, flags_in, rf_rdata, mem_ack, mem_rdata,
           alu_res, alu_flags,
    input  req_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, flags_we, flags_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, alu_a, alu_b, alu_op, alu_cin, done
  );
endinterface

// File: rtl/cb_exec_ctrl.sv
// CB-prefix sequencer: fetches the operand (register or (HL)), runs it through
// alu8 and writes back result/flags, with read-modify-write for memory operands.
//
//   state  | meaning
//   IDLE   | waiting for a CB opcode
//   EXEC   | register operand: ALU cycle plus write-back
//   MRD    | reading the byte at (HL)
//   MEXEC  | ALU cycle on the fetched byte
//   MWR    | writing the result back to (HL)
module cb_exec_ctrl (
  input  logic clk,
  input  logic rst_n,
  cb_exec_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MRD   = 3'd2;
  localparam logic [2:0] S_MEXEC = 3'd3;
  localparam logic [2:0] S_MWR   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        ready_q;
  logic [7:0]  op_q;
  logic [15:0] hl_q;
  logic [7:0]  dat_q;
  logic [7:0]  res_q;

  logic        is_shift, is_bit, alu_active;
  logic [4:0]  alu_opc;

  assign is_shift   = (op_q[7:6] == 2'b00);
  assign is_bit     = (op_q[7:6] == 2'b01);
  assign alu_active = (state_q == S_EXEC) || (state_q == S_MEXEC);

  always_comb begin
    alu_opc = 5'b00000;
    case (op_q[7:6])
      2'b00: begin
        case (op_q[5:3])
          3'd0: alu_opc = 5'b01100;
          3'd1: alu_opc = 5'b01101;
          3'd2: alu_opc = 5'b01000;
          3'd3: alu_opc = 5'b01001;
          3'd4: alu_opc = 5'b10000;
          3'd5: alu_opc = 5'b10001;
          3'd6: alu_opc = 5'b10011;
          default: alu_opc = 5'b10010;
        endcase
      end
      2'b01:   alu_opc = 5'b10100;
      2'b10:   alu_opc = 5'b10101;
      default: alu_opc = 5'b10110;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q)
          state_d = (bus.req_op[2:0] == 3'd6) ? S_MRD : S_EXEC;
      end
      S_EXEC:  state_d = S_IDLE;
      S_MRD:   if (bus.mem_ack) state_d = S_MEXEC;
      S_MEXEC: state_d = is_bit ? S_IDLE : S_MWR;
      S_MWR:   if (bus.mem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ready is a registered copy of "next state is IDLE", so it stays low in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      op_q    <= 8'h00;
      hl_q    <= 16'h0000;
      dat_q   <= 8'h00;
      res_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      if (state_q == S_IDLE && bus.req_valid && ready_q) begin
        op_q <= bus.req_op;
        hl_q <= bus.hl_in;
      end
      if (state_q == S_MRD && bus.mem_ack)
        dat_q <= bus.mem_rdata;
      if (state_q == S_MEXEC)
        res_q <= bus.alu_res;
    end
  end

  assign bus.req_ready = ready_q;

  assign bus.rf_raddr = (state_q == S_EXEC) ? op_q[2:0] : 3'd0;
  assign bus.alu_a    = (state_q == S_EXEC)  ? bus.rf_rdata :
                        (state_q == S_MEXEC) ? dat_q : 8'h00;
  assign bus.alu_b    = alu_active ? {5'b00000, op_q[5:3]} : 8'h00;
  assign bus.alu_op   = alu_active ? alu_opc : 5'b00000;
  assign bus.alu_cin  = alu_active & bus.flags_in[4];

  assign bus.rf_we    = (state_q == S_EXEC) && !is_bit;
  assign bus.rf_waddr = bus.rf_we ? op_q[2:0] : 3'd0;
  assign bus.rf_wdata = bus.rf_we ? bus.alu_res : 8'h00;

  // BIT keeps the incoming carry; RES/SET leave F untouched
  assign bus.flags_we    = alu_active && (is_shift || is_bit);
  assign bus.flags_wdata = !bus.flags_we ? 8'h00 :
                           is_bit ? {bus.alu_flags[7:5], bus.flags_in[4], 4'b0000} :
                                    {bus.alu_flags[7:4], 4'b0000};

  assign bus.mem_req   = (state_q == S_MRD) || (state_q == S_MWR);
  assign bus.mem_we    = (state_q == S_MWR);
  assign bus.mem_addr  = bus.mem_req ? hl_q : 16'h0000;
  assign bus.mem_wdata = (state_q == S_MWR) ? res_q : 8'h00;

  assign bus.done = (state_q == S_EXEC) ||
                    ((state_q == S_MEXEC) && is_bit) ||
                    ((state_q == S_MWR) && bus.mem_ack);

  logic unused_bits;
  assign unused_bits = ^{bus.alu_flags[3:0], bus.flags_in[7:5], bus.flags_in[3:0]};

endmodule

// File: tb/tb_cb_exec_ctrl.sv
// Scoreboard bench for cb_exec_ctrl: directed CB opcodes with hand-computed results,
// a behavioural alu8, register file and wait-state memory around the DUT.
module tb_cb_exec_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cb_exec_if bus ();
  cb_exec_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        rf_we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic        fl_we;
    logic [7:0]  fl;
    logic        mr;
    logic [15:0] raddr;
    logic        mw;
    logic [15:0] maddr;
    logic [7:0]  mdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   mem_wr_total = 0;

  // register file and alu8 models
  logic [7:0] regs [8];
  assign bus.rf_rdata = regs[bus.rf_raddr];

  function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [7:0] a,
                                            input logic [2:0] b, input logic cin);
    logic [7:0] r;
    logic [7:0] f;
    logic       c;
    r = a;
    c = 1'b0;
    case (op)
      5'b01100: begin r = {a[6:0], a[7]}; c = a[7]; end
      5'b01101: begin r = {a[0], a[7:1]}; c = a[0]; end
      5'b01000: begin r = {a[6:0], cin};  c = a[7]; end
      5'b01001: begin r = {cin, a[7:1]};  c = a[0]; end
      5'b10000: begin r = {a[6:0], 1'b0}; c = a[7]; end
      5'b10001: begin r = {a[7], a[7:1]}; c = a[0]; end
      5'b10011: begin r = {a[3:0], a[7:4]}; c = 1'b0; end
      5'b10010: begin r = {1'b0, a[7:1]}; c = a[0]; end
      5'b10101: r = a & ~(8'h01 << b);
      5'b10110: r = a | (8'h01 << b);
      default:  r = a;
    endcase
    f = {(r == 8'h00), 1'b0, 1'b0, c, 4'hF};
    if (op == 5'b10100) f = {~a[b], 1'b0, 1'b1, 1'b0, 4'hF};
    if (op == 5'b10101 || op == 5'b10110) f = 8'hFF;
    return {f, r};
  endfunction

  assign {bus.alu_flags, bus.alu_res} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b[2:0], bus.alu_cin);

  // memory responder with programmable wait states
  int         rd_wait = 0;
  int         wr_wait = 0;
  logic [7:0] rd_data = 8'h00;
  logic       mem_ack_r = 1'b0;
  logic [7:0] mem_rdata_r = 8'h00;
  int         wcnt = 0;
  assign bus.mem_ack   = mem_ack_r;
  assign bus.mem_rdata = mem_rdata_r;

  always @(posedge clk) begin
    #1;
    mem_ack_r = 1'b0;
    if (!rst_n || !bus.mem_req) begin
      wcnt = 0;
    end else if (wcnt >= (bus.mem_we ? wr_wait : rd_wait)) begin
      mem_ack_r   = 1'b1;
      mem_rdata_r = bus.mem_we ? 8'h00 : rd_data;
      wcnt = 0;
    end else begin
      wcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic rf_we, input logic [2:0] waddr, input logic [7:0] wdata,
                              input logic fl_we, input logic [7:0] fl,
                              input logic mr, input logic [15:0] raddr,
                              input logic mw, input logic [15:0] maddr, input logic [7:0] mdata,
                              input int lat);
    exp_t e;
    e.rf_we = rf_we; e.waddr = waddr; e.wdata = wdata;
    e.fl_we = fl_we; e.fl = fl;
    e.mr = mr; e.raddr = raddr;
    e.mw = mw; e.maddr = maddr; e.mdata = mdata;
    e.lat = lat;
    return e;
  endfunction

  // monitor: accumulate what the DUT does for one instruction, compare on done
  exp_t        obs;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pend_ready = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [24:0] prev_bus = '0;

  task automatic clear_obs();
    obs = mk(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 8'h00, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      clear_obs();
      pend_ready = 0;
      prev_req   = 1'b0;
    end else begin
      cyc++;
      if (pend_ready) begin
        chk("ready_after_done", bus.req_ready, 1);
        pend_ready = 0;
      end
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      if (bus.mem_req) begin
        if (prev_req && !prev_ack)
          chk("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, prev_bus);
      end else begin
        chk("mem_idle_zero", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      end
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
      prev_bus = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (bus.rf_we) begin
        obs.rf_we = 1'b1; obs.waddr = bus.rf_waddr; obs.wdata = bus.rf_wdata;
      end
      if (bus.flags_we) begin
        obs.fl_we = 1'b1; obs.fl = bus.flags_wdata;
      end
      if (bus.mem_req && bus.mem_ack && !bus.mem_we) begin
        obs.mr = 1'b1; obs.raddr = bus.mem_addr;
      end
      if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
        obs.mw = 1'b1; obs.maddr = bus.mem_addr; obs.mdata = bus.mem_wdata;
        mem_wr_total++;
      end
      if (bus.done) begin
        exp_t e;
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done with no instruction expected at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rf_we", obs.rf_we, e.rf_we);
          chk("rf_waddr", obs.waddr, e.waddr);
          chk("rf_wdata", obs.wdata, e.wdata);
          chk("flags_we", obs.fl_we, e.fl_we);
          chk("flags_wdata", obs.fl, e.fl);
          chk("mem_read", {obs.mr, obs.raddr}, {e.mr, e.raddr});
          chk("mem_write", {obs.mw, obs.maddr, obs.mdata}, {e.mw, e.maddr, e.mdata});
          chk("latency", cyc - acc_cyc, e.lat);
        end
        clear_obs();
        pend_ready = 1;
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [15:0] hl, input logic [7:0] f,
                       input exp_t e, input bit push, input bit wait_done);
    int n;
    int d0;
    n = 0;
    while (!bus.req_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("ready_wait", bus.req_ready, 1);
    bus.flags_in  = f;
    bus.hl_in     = hl;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    if (push) exp_q.push_back(e);
    d0 = done_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 8'h00;
    bus.hl_in     = 16'h0000;
    if (wait_done) begin
      n = 0;
      while (done_cnt == d0 && n < 60) begin @(posedge clk); #1; n++; end
      chk("done_timeout", done_cnt != d0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wr_before;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_op    = 8'h00;
    bus.hl_in     = 16'h0000;
    bus.flags_in  = 8'h00;
    clear_obs();

    #12;
    chk("reset_ready", bus.req_ready, 0);
    chk("reset_strobes", {bus.done, bus.mem_req, bus.mem_we, bus.rf_we, bus.flags_we}, 0);
    chk("reset_data", {bus.mem_addr, bus.mem_wdata, bus.rf_wdata, bus.flags_wdata, bus.alu_a}, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.req_ready, 1);

    regs[0] = 8'h85;
    issue(8'h00, 16'h0, 8'h00, mk(1, 3'd0, 8'h0B, 1, 8'h10, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);
    regs[1] = 8'h80;
    issue(8'h11, 16'h0, 8'h10, mk(1, 3'd1, 8'h01, 1, 8'h10, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);
    regs[7] = 8'h00;
    issue(8'h37, 16'h0, 8'h00, mk(1, 3'd7, 8'h00, 1, 8'h80, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);
    regs[4] = 8'h7F;
    issue(8'h7C, 16'h0, 8'h10, mk(0, 3'd0, 8'h00, 1, 8'hB0, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);
    regs[5] = 8'hFF;
    issue(8'h85, 16'h0, 8'hF0, mk(1, 3'd5, 8'hFE, 0, 8'h00, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);
    regs[2] = 8'h01;
    issue(8'h1A, 16'h0, 8'h10, mk(1, 3'd2, 8'h80, 1, 8'h10, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);
    regs[3] = 8'h01;
    issue(8'h3B, 16'h0, 8'h00, mk(1, 3'd3, 8'h00, 1, 8'h90, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);

    rd_wait = 1; rd_data = 8'h01;
    issue(8'h46, 16'h1234, 8'h10, mk(0, 3'd0, 8'h00, 1, 8'h30, 1, 16'h1234, 0, 16'h0, 8'h00, 3), 1, 1);
    rd_wait = 2; wr_wait = 1; rd_data = 8'h00;
    issue(8'hDE, 16'hC000, 8'h00, mk(0, 3'd0, 8'h00, 0, 8'h00, 1, 16'hC000, 1, 16'hC000, 8'h08, 6), 1, 1);
    rd_wait = 0; wr_wait = 0; rd_data = 8'h81;
    issue(8'h2E, 16'h8001, 8'h00, mk(0, 3'd0, 8'h00, 1, 8'h10, 1, 16'h8001, 1, 16'h8001, 8'hC0, 3), 1, 1);

    // reset while the write-back of SET 3,(HL) is still waiting for its ack
    rd_wait = 0; wr_wait = 30; rd_data = 8'h00;
    wr_before = mem_wr_total;
    issue(8'hDE, 16'hC000, 8'h00, mk(0, 3'd0, 8'h00, 0, 8'h00, 0, 16'h0, 0, 16'h0, 8'h00, 0), 0, 0);
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 20) begin @(posedge clk); #1; n++; end
    chk("mwr_reached", bus.mem_req & bus.mem_we, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", {bus.mem_req, bus.mem_we}, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ready", bus.req_ready, 0);
    wr_wait = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("ready_before_edge", bus.req_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_rerelease", bus.req_ready, 1);
    chk("no_write_after_reset", mem_wr_total, wr_before);

    regs[0] = 8'h85;
    issue(8'h00, 16'h0, 8'h00, mk(1, 3'd0, 8'h0B, 1, 8'h10, 0, 16'h0, 0, 16'h0, 8'h00, 1), 1, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("no_stray_write", mem_wr_total, wr_before);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
